// File: rtl/alu_bcd_display_scan.sv
// Two-digit multiplexed 7-segment driver for the ALU BCD result, with blank gaps,
// frame-aligned updates and error blinking. Define LEAD_ZERO_BLANK_EN to blank a leading tens zero.
module alu_bcd_display_scan #(
    parameter int REFRESH_DIV = 1000,
    parameter int GAP_CYCLES  = 8,
    parameter int BLINK_DIV   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] dec_in,
    input  logic [3:0] unis_in,
    input  logic       zero_in,
    input  logic       error_in,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       zero_led,
    output logic       error_led,
    output logic       frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    typedef enum logic [2:0] {IDLE, GAP_U, UNITS, GAP_T, TENS} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       hold_tens_q, hold_units_q;
    logic             hold_zero_q, hold_err_q, have_data_q;
    logic [3:0]       sh_tens_q, sh_tens_d, sh_units_q, sh_units_d;
    logic             sh_zero_q, sh_zero_d, sh_err_q, sh_err_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blk_off_q, blk_off_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       dig_en_q, dig_en_d;
    logic             zero_led_q, error_led_q, frame_tick_q, frame_tick_d;
    logic             sh_upd, frame_end, blank_err, show_tens;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            4'd15:   s = 7'h40;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_tens_d    = sh_tens_q;
        sh_units_d   = sh_units_q;
        sh_zero_d    = sh_zero_q;
        sh_err_d     = sh_err_q;
        blk_cnt_d    = blk_cnt_q;
        blk_off_d    = blk_off_q;
        seg_d        = 7'h00;
        dig_en_d     = 2'b00;
        show_tens    = 1'b0;
        sh_upd       = (state_q == GAP_U) && (cnt_q == '0);
        frame_end    = (state_q == TENS) && (cnt_q == SLOT_LAST);

        case (state_q)
            IDLE: begin
                if (load || have_data_q) begin
                    state_d = GAP_U;
                    cnt_d   = '0;
                end
            end
            GAP_U: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) state_d = UNITS;
            end
            UNITS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SLOT_LAST) begin
                    state_d = GAP_T;
                    cnt_d   = '0;
                end
            end
            GAP_T: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) state_d = TENS;
            end
            TENS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SLOT_LAST) begin
                    state_d = GAP_U;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A load in the very cycle of the shadow copy bypasses the holding registers.
        if (sh_upd) begin
            sh_tens_d  = load ? dec_in   : hold_tens_q;
            sh_units_d = load ? unis_in  : hold_units_q;
            sh_zero_d  = load ? zero_in  : hold_zero_q;
            sh_err_d   = load ? error_in : hold_err_q;
        end

        if (sh_upd && sh_err_d && !sh_err_q) begin
            blk_cnt_d = '0;
            blk_off_d = 1'b0;
        end else if (frame_end) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                blk_off_d = ~blk_off_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end

        // Outputs are derived from next-state values so they line up with the slot counter.
        blank_err = sh_err_d & blk_off_d;
        case (state_d)
            UNITS: begin
                if (!blank_err) begin
                    seg_d    = sh_err_d ? 7'h40 : seg_decode(sh_units_d);
                    dig_en_d = 2'b01;
                end
            end
            TENS: begin
                show_tens = !blank_err;
`ifdef LEAD_ZERO_BLANK_EN
                if (!sh_err_d && (sh_tens_d == 4'd0)) show_tens = 1'b0;
`endif
                if (show_tens) begin
                    seg_d    = sh_err_d ? 7'h40 : seg_decode(sh_tens_d);
                    dig_en_d = 2'b10;
                end
            end
            default: ;
        endcase

        frame_tick_d = (state_d == TENS) && (cnt_d == SLOT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_tens_q  <= '0;
            hold_units_q <= '0;
            hold_zero_q  <= 1'b0;
            hold_err_q   <= 1'b0;
            have_data_q  <= 1'b0;
            sh_tens_q    <= '0;
            sh_units_q   <= '0;
            sh_zero_q    <= 1'b0;
            sh_err_q     <= 1'b0;
            blk_cnt_q    <= '0;
            blk_off_q    <= 1'b0;
            seg_q        <= '0;
            dig_en_q     <= '0;
            zero_led_q   <= 1'b0;
            error_led_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            if (load) begin
                hold_tens_q  <= dec_in;
                hold_units_q <= unis_in;
                hold_zero_q  <= zero_in;
                hold_err_q   <= error_in;
                have_data_q  <= 1'b1;
            end
            sh_tens_q    <= sh_tens_d;
            sh_units_q   <= sh_units_d;
            sh_zero_q    <= sh_zero_d;
            sh_err_q     <= sh_err_d;
            blk_cnt_q    <= blk_cnt_d;
            blk_off_q    <= blk_off_d;
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
            zero_led_q   <= sh_zero_d & ~sh_err_d;
            error_led_q  <= sh_err_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dig_en     = dig_en_q;
    assign zero_led   = zero_led_q;
    assign error_led  = error_led_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_alu_bcd_display_scan.sv
// Bench for alu_bcd_display_scan: table of loads with a per-cycle expected-output queue,
// plus hand sequences for last-load-wins, coincident load and asynchronous reset.
module tb_alu_bcd_display_scan;

    localparam int RD    = 16;
    localparam int G     = 2;
    localparam int BD    = 2;
    localparam int FRAME = 2 * RD;

    typedef struct {
        logic [3:0] dec;
        logic [3:0] unis;
        logic       zero;
        logic       err;
        logic [6:0] useg;
        logic [6:0] tseg;
        logic       zled;
        logic       eled;
    } vec_t;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] dig;
        logic       zl;
        logic       el;
        logic       ft;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] dec_in = '0;
    logic [3:0] unis_in = '0;
    logic       zero_in = 1'b0;
    logic       error_in = 1'b0;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       zero_led, error_led, frame_tick;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    vec_t tbl[9];
    vec_t vz, m_hold, m_sh, va7, va9, vb3;
    int   m_pos = -1;
    int   m_fidx = 0;

    alu_bcd_display_scan #(.REFRESH_DIV(RD), .GAP_CYCLES(G), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .load(load), .dec_in(dec_in), .unis_in(unis_in),
        .zero_in(zero_in), .error_in(error_in), .seg(seg), .dig_en(dig_en),
        .zero_led(zero_led), .error_led(error_led), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic out_t cur_out();
        out_t o;
        o = {seg, dig_en, zero_led, error_led, frame_tick};
        return o;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge with the given inputs.
    task automatic model_edge(input logic ld, input vec_t v);
        int   np;
        vec_t ns;
        np = (m_pos < 0) ? (ld ? 0 : -1) : (m_pos + 1) % FRAME;
        if (m_pos == 0) begin
            ns = ld ? v : m_hold;
            if (ns.err && !m_sh.err) m_fidx = 0;
            m_sh = ns;
        end
        if (m_pos == FRAME - 1) m_fidx++;
        if (ld) m_hold = v;
        m_pos = np;
    endtask

    function automatic out_t model_out();
        out_t o;
        logic off;
        o    = '0;
        o.zl = m_sh.zled;
        o.el = m_sh.eled;
        off  = m_sh.err && (((m_fidx / BD) % 2) == 1);
        if (m_pos >= G && m_pos < RD && !off) begin
            o.seg = m_sh.useg;
            o.dig = 2'b01;
        end
        if (m_pos >= RD + G && !off) begin
            o.seg = m_sh.tseg;
            o.dig = 2'b10;
`ifdef LEAD_ZERO_BLANK_EN
            if (!m_sh.err && m_sh.dec == 4'd0) begin
                o.seg = 7'h00;
                o.dig = 2'b00;
            end
`endif
        end
        o.ft = (m_pos == FRAME - 1);
        return o;
    endfunction

    // Called at a negedge: drive one cycle, queue the expectation, compare at the next negedge.
    task automatic step(input logic ld, input vec_t v);
        out_t e;
        load     = ld;
        dec_in   = v.dec;
        unis_in  = v.unis;
        zero_in  = v.zero;
        error_in = v.err;
        model_edge(ld, v);
        exp_q.push_back(model_out());
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (cur_out() !== e) begin
                errors++;
                $display("FAIL cycle pos=%0d: got seg=%h dig=%b zl=%b el=%b ft=%b expected seg=%h dig=%b zl=%b el=%b ft=%b",
                         m_pos, seg, dig_en, zero_led, error_led, frame_tick,
                         e.seg, e.dig, e.zl, e.el, e.ft);
            end
        end
        load = 1'b0;
    endtask

    task automatic run_to(input int p);
        for (int k = 0; k < 2 * FRAME && m_pos != p; k++) step(1'b0, vz);
        checks++;
        if (m_pos != p) begin
            errors++;
            $display("FAIL run_to: position %0d expected %0d", m_pos, p);
        end
    endtask

    initial begin
        vz     = '{4'd0, 4'd0, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0};
        m_hold = vz;
        m_sh   = vz;
        tbl[0] = '{4'd4,  4'd2,  1'b0, 1'b0, 7'h5B, 7'h66, 1'b0, 1'b0};
        tbl[1] = '{4'd0,  4'd0,  1'b1, 1'b0, 7'h3F, 7'h3F, 1'b1, 1'b0};
        tbl[2] = '{4'd15, 4'd15, 1'b0, 1'b1, 7'h40, 7'h40, 1'b0, 1'b1};
        tbl[3] = '{4'd9,  4'd8,  1'b0, 1'b0, 7'h7F, 7'h6F, 1'b0, 1'b0};
        tbl[4] = '{4'd12, 4'd11, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0};
        tbl[5] = '{4'd3,  4'd5,  1'b0, 1'b0, 7'h6D, 7'h4F, 1'b0, 1'b0};
        tbl[6] = '{4'd7,  4'd1,  1'b0, 1'b0, 7'h06, 7'h07, 1'b0, 1'b0};
        tbl[7] = '{4'd6,  4'd15, 1'b0, 1'b0, 7'h40, 7'h7D, 1'b0, 1'b0};
        tbl[8] = '{4'd3,  4'd4,  1'b1, 1'b1, 7'h40, 7'h40, 1'b0, 1'b1};
        va7    = '{4'd0,  4'd7,  1'b0, 1'b0, 7'h07, 7'h3F, 1'b0, 1'b0};
        va9    = '{4'd0,  4'd9,  1'b0, 1'b0, 7'h6F, 7'h3F, 1'b0, 1'b0};
        vb3    = '{4'd0,  4'd3,  1'b0, 1'b0, 7'h4F, 7'h3F, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", cur_out(), 12'h000);
        reset = 1'b1;

        // Idle: no load, everything stays dark and no frame ticks
        repeat (200) step(1'b0, vz);

        // Table-driven loads at varying frame positions
        for (int i = 0; i < 9; i++) begin
            if (m_pos >= 0) run_to((i * 9) % FRAME);
            step(1'b1, tbl[i]);
            repeat ((tbl[i].err ? 5 : 2) * FRAME) step(1'b0, vz);
            run_to(8);
            chk($sformatf("leds_vec%0d", i), {10'h0, zero_led, error_led},
                {10'h0, tbl[i].zled, tbl[i].eled});
            if (!tbl[i].err)
                chk($sformatf("units_vec%0d", i), {3'h0, seg, dig_en},
                    {3'h0, tbl[i].useg, 2'b01});
        end

        // Two loads in one frame: the later one is displayed
        run_to(3);
        step(1'b1, va7);
        run_to(20);
        step(1'b1, va9);
        run_to(FRAME - 1);
        run_to(5);
        chk("last_load_wins", {3'h0, seg, dig_en}, {3'h0, 7'h6F, 2'b01});

        // Load coincident with the first gap cycle shows in that same frame
        run_to(0);
        step(1'b1, vb3);
        run_to(5);
        chk("coincident_load", {3'h0, seg, dig_en}, {3'h0, 7'h4F, 2'b01});

        // Asynchronous reset in the middle of the tens slot
        run_to(24);
        chk("pre_reset_tens", {10'h0, dig_en}, {10'h0, 2'b10});
        #2 reset = 1'b0;
        #1 chk("async_reset_clear", cur_out(), 12'h000);
        exp_q.delete();
        m_pos  = -1;
        m_hold = vz;
        m_sh   = vz;
        m_fidx = 0;
        @(negedge clk);
        chk("reset_held", cur_out(), 12'h000);
        reset = 1'b1;
        repeat (40) step(1'b0, vz);
        step(1'b1, tbl[0]);
        repeat (FRAME + 8) step(1'b0, vz);
        chk("resume_after_reset", {3'h0, seg, dig_en}, {3'h0, 7'h5B, 2'b01});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
